// File: rtl/tone_phase_bank_pkg.sv
// Shared constants, loader state encoding and the note increment table for
// the multi-channel tone phase generator.
package tone_phase_bank_pkg;

  localparam int NOTE_W = 5;
  localparam int NOTES  = 24;
  localparam int OCT_W  = 2;
  localparam int JUMP_W = 7;
  localparam int REM_W  = 29;
  // Wide enough for a base jump shifted up by the largest octave.
  localparam int INC_W  = JUMP_W + (1 << OCT_W) - 1;

  localparam logic [REM_W-1:0] FRAC_DEN = 29'd100000000;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_LOOKUP = 2'd1,
    LD_SHIFT  = 2'd2,
    LD_COMMIT = 2'd3
  } ld_state_e;

  typedef struct packed {
    logic [JUMP_W-1:0] jump;
    logic [REM_W-1:0]  rem;
  } note_inc_t;

  // Phase increment per sample, as integer jump plus rem/FRAC_DEN.
  function automatic note_inc_t note_table(input logic [NOTE_W-1:0] idx);
    note_inc_t e;
    case (idx)
      5'd0:    e = '{7'd16, 29'd74403618};
      5'd1:    e = '{7'd17, 29'd73968838};
      5'd2:    e = '{7'd18, 29'd79454515};
      5'd3:    e = '{7'd19, 29'd91212696};
      5'd4:    e = '{7'd21, 29'd9616364};
      5'd5:    e = '{7'd22, 29'd35060681};
      5'd6:    e = '{7'd23, 29'd67964305};
      5'd7:    e = '{7'd25, 29'd8770790};
      5'd8:    e = '{7'd26, 29'd57950065};
      5'd9:    e = '{7'd28, 29'd16000000};
      5'd10:   e = '{7'd29, 29'd83448074};
      5'd11:   e = '{7'd31, 29'd60853128};
      5'd12:   e = '{7'd33, 29'd48807236};
      5'd13:   e = '{7'd35, 29'd47937677};
      5'd14:   e = '{7'd37, 29'd58909029};
      5'd15:   e = '{7'd39, 29'd82425392};
      5'd16:   e = '{7'd42, 29'd19232728};
      5'd17:   e = '{7'd44, 29'd70121362};
      5'd18:   e = '{7'd47, 29'd35928611};
      5'd19:   e = '{7'd50, 29'd17541581};
      5'd20:   e = '{7'd53, 29'd15900129};
      5'd21:   e = '{7'd56, 29'd32000000};
      5'd22:   e = '{7'd59, 29'd66896147};
      5'd23:   e = '{7'd63, 29'd21706256};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/tone_phase_bank_rom.sv
// Combinational note index to (jump, rem) lookup; out-of-range notes give
// a zero increment so key-off needs no special path.
module tone_note_rom
  import tone_phase_bank_pkg::*;
(
  input  logic [NOTE_W-1:0] note_i,
  output logic [JUMP_W-1:0] jump_o,
  output logic [REM_W-1:0]  rem_o
);

  note_inc_t entry;

  always_comb begin
    entry = note_table(note_i);
    if (note_i >= NOTE_W'(NOTES)) begin
      entry = '0;
    end
    jump_o = entry.jump;
    rem_o  = entry.rem;
  end

endmodule

// File: rtl/tone_phase_bank.sv
// Multi-channel phase accumulator bank with a shared note loader that turns
// note plus octave into a jump/remainder increment, one octave per cycle.
module tone_phase_bank
  import tone_phase_bank_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int PHASE_W  = 16,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [CH_W-1:0]               note_chan,
  input  logic [NOTE_W-1:0]             note,
  input  logic [OCT_W-1:0]              octave,
  input  logic                          retrig,
  output logic [CHANNELS*PHASE_W-1:0]   phase,
  output logic [CHANNELS-1:0]           active,
  output ld_state_e                     dbg_state
);

  // Handshake: a load transfers on any cycle where note_valid && note_ready;
  // note_ready is high only while the loader sits in LD_IDLE.

  ld_state_e          state_q, state_d;
  logic [CH_W-1:0]    chan_q, chan_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [OCT_W-1:0]   oct_q, oct_d;
  logic               retrig_q, retrig_d;
  logic [OCT_W-1:0]   cnt_q, cnt_d;
  logic [INC_W-1:0]   j_q, j_d;
  logic [REM_W-1:0]   r_q, r_d;
  logic [REM_W:0]     r2;

  logic [JUMP_W-1:0]  rom_jump;
  logic [REM_W-1:0]   rom_rem;
  logic               koff;

  logic [PHASE_W-1:0] phase_q [CHANNELS];
  logic [PHASE_W-1:0] phase_d [CHANNELS];
  logic [REM_W-1:0]   frac_q  [CHANNELS];
  logic [REM_W-1:0]   frac_d  [CHANNELS];
  logic [INC_W-1:0]   jump_q  [CHANNELS];
  logic [INC_W-1:0]   jump_d  [CHANNELS];
  logic [REM_W-1:0]   rem_q   [CHANNELS];
  logic [REM_W-1:0]   rem_d   [CHANNELS];
  logic [CHANNELS-1:0] active_q, active_d;

  tone_note_rom u_rom (
    .note_i (note_q),
    .jump_o (rom_jump),
    .rem_o  (rom_rem)
  );

  assign koff = (note_q >= NOTE_W'(NOTES));

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    note_d   = note_q;
    oct_d    = oct_q;
    retrig_d = retrig_q;
    cnt_d    = cnt_q;
    j_d      = j_q;
    r_d      = r_q;
    r2       = {r_q, 1'b0};
    case (state_q)
      LD_IDLE: begin
        if (note_valid) begin
          chan_d   = note_chan;
          note_d   = note;
          oct_d    = octave;
          retrig_d = retrig;
          state_d  = LD_LOOKUP;
        end
      end
      LD_LOOKUP: begin
        j_d   = INC_W'(rom_jump);
        r_d   = rom_rem;
        cnt_d = oct_q;
        state_d = (koff || oct_q == '0) ? LD_COMMIT : LD_SHIFT;
      end
      LD_SHIFT: begin
        // r < FRAC_DEN on entry, so 2r needs at most one subtraction.
        if (r2 >= {1'b0, FRAC_DEN}) begin
          r2  = r2 - {1'b0, FRAC_DEN};
          j_d = {j_q[INC_W-2:0], 1'b1};
        end else begin
          j_d = {j_q[INC_W-2:0], 1'b0};
        end
        r_d   = r2[REM_W-1:0];
        cnt_d = cnt_q - OCT_W'(1);
        if (cnt_q == OCT_W'(1)) begin
          state_d = LD_COMMIT;
        end
      end
      LD_COMMIT: begin
        state_d = LD_IDLE;
      end
      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  always_comb begin
    logic [REM_W-1:0] sum;
    logic             carry;
    active_d = active_q;
    for (int i = 0; i < CHANNELS; i++) begin
      phase_d[i] = phase_q[i];
      frac_d[i]  = frac_q[i];
      jump_d[i]  = jump_q[i];
      rem_d[i]   = rem_q[i];
      sum        = frac_q[i] + rem_q[i];
      carry      = (sum >= FRAC_DEN);
      if (sample_tick) begin
        if (active_q[i]) begin
          frac_d[i]  = carry ? (sum - FRAC_DEN) : sum;
          phase_d[i] = phase_q[i] + PHASE_W'(jump_q[i]) + PHASE_W'(carry);
        end else begin
          phase_d[i] = '0;
          frac_d[i]  = '0;
        end
      end
      // A commit overrides a coincident tick only when it resets the phase.
      if (state_q == LD_COMMIT && chan_q == CH_W'(i)) begin
        jump_d[i]   = j_q;
        rem_d[i]    = r_q;
        active_d[i] = !koff;
        if (retrig_q || koff) begin
          phase_d[i] = '0;
          frac_d[i]  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LD_IDLE;
      chan_q   <= '0;
      note_q   <= '0;
      oct_q    <= '0;
      retrig_q <= 1'b0;
      cnt_q    <= '0;
      j_q      <= '0;
      r_q      <= '0;
      active_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= '0;
        frac_q[i]  <= '0;
        jump_q[i]  <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      note_q   <= note_d;
      oct_q    <= oct_d;
      retrig_q <= retrig_d;
      cnt_q    <= cnt_d;
      j_q      <= j_d;
      r_q      <= r_d;
      active_q <= active_d;
      for (int i = 0; i < CHANNELS; i++) begin
        phase_q[i] <= phase_d[i];
        frac_q[i]  <= frac_d[i];
        jump_q[i]  <= jump_d[i];
        rem_q[i]   <= rem_d[i];
      end
    end
  end

  assign note_ready = (state_q == LD_IDLE);
  assign active     = active_q;
  assign dbg_state  = state_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_phase_out
    assign phase[g*PHASE_W +: PHASE_W] = phase_q[g];
  end

endmodule

// File: tb/tb_tone_phase_bank.sv
// Self-checking bench for tone_phase_bank: directed scenarios plus random
// loads and ticks against a fixed-point arithmetic reference model.
module tb_tone_phase_bank;
  import tone_phase_bank_pkg::*;

  localparam longint DEN = 100000000;

  logic        clk, rst, sample_tick, note_valid, note_ready, retrig;
  logic [1:0]  note_chan, octave;
  logic [4:0]  note;
  logic [63:0] phase;
  logic [3:0]  active;
  ld_state_e   dbg_state;

  int total, bad;
  logic [63:0] exp_q[$];

  // Increments in units of 1e-8 of a phase step: f = 28.16 * 2^((n-9)/12).
  longint tab [24] = '{
    64'd1674403618, 64'd1773968838, 64'd1879454515, 64'd1991212696,
    64'd2109616364, 64'd2235060681, 64'd2367964305, 64'd2508770790,
    64'd2657950065, 64'd2816000000, 64'd2983448074, 64'd3160853128,
    64'd3348807236, 64'd3547937677, 64'd3758909029, 64'd3982425392,
    64'd4219232728, 64'd4470121362, 64'd4735928611, 64'd5017541581,
    64'd5315900129, 64'd5632000000, 64'd5966896147, 64'd6321706256};

  longint m_phase [4];
  longint m_frac  [4];
  longint m_jump  [4];
  longint m_rem   [4];
  bit [3:0] m_active;
  int pend;
  int p_chan, p_note, p_oct;
  bit p_retrig;

  tone_phase_bank dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .note_valid  (note_valid),
    .note_ready  (note_ready),
    .note_chan   (note_chan),
    .note        (note),
    .octave      (octave),
    .retrig      (retrig),
    .phase       (phase),
    .active      (active),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ph(input int c);
    return phase[c*16 +: 16];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_phase[c] = 0; m_frac[c] = 0; m_jump[c] = 0; m_rem[c] = 0;
    end
    m_active = '0;
    pend = 0;
  endtask

  task automatic compare_outputs();
    logic [63:0] ev, e;
    chk("ready", 64'(note_ready), 64'(pend == 0));
    chk("active", 64'(active), 64'(m_active));
    for (int c = 0; c < 4; c++) ev[c*16 +: 16] = 16'(m_phase[c]);
    exp_q.push_back(ev);
    e = exp_q.pop_front();
    for (int c = 0; c < 4; c++)
      chk($sformatf("phase%0d", c), 64'(ph(c)), 64'(e[c*16 +: 16]));
  endtask

  task automatic do_reset();
    rst = 1'b1; sample_tick = 1'b0; note_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    compare_outputs();
  endtask

  // One clock: drive inputs, advance the model for this edge, then check.
  task automatic step(input bit tk, input bit v, input int ch, input int nt,
                      input int oc, input bit rt);
    bit xfer, commit;
    longint tot;
    sample_tick = tk; note_valid = v; note_chan = 2'(ch);
    note = 5'(nt); octave = 2'(oc); retrig = rt;
    xfer   = v && (pend == 0);
    commit = (pend == 1);
    if (tk) begin
      for (int c = 0; c < 4; c++) begin
        if (m_active[c]) begin
          longint carry;
          m_frac[c] = m_frac[c] + m_rem[c];
          carry = (m_frac[c] >= DEN) ? 1 : 0;
          m_frac[c] = m_frac[c] - carry * DEN;
          m_phase[c] = (m_phase[c] + m_jump[c] + carry) % 65536;
        end else begin
          m_phase[c] = 0; m_frac[c] = 0;
        end
      end
    end
    if (commit) begin
      if (p_note >= 24) begin
        m_jump[p_chan] = 0; m_rem[p_chan] = 0;
        m_phase[p_chan] = 0; m_frac[p_chan] = 0;
        m_active[p_chan] = 1'b0;
      end else begin
        tot = tab[p_note] << p_oct;
        m_jump[p_chan] = tot / DEN;
        m_rem[p_chan]  = tot % DEN;
        m_active[p_chan] = 1'b1;
        if (p_retrig) begin
          m_phase[p_chan] = 0; m_frac[p_chan] = 0;
        end
      end
    end
    if (pend > 0) pend--;
    if (xfer) begin
      p_chan = ch; p_note = nt; p_oct = oc; p_retrig = rt;
      pend = (nt >= 24) ? 2 : 2 + oc;
    end
    @(posedge clk); #1;
    compare_outputs();
  endtask

  task automatic load(input int ch, input int nt, input int oc, input bit rt, input bit tk);
    step(tk, 1'b1, ch, nt, oc, rt);
    for (int k = 0; k < 8 && pend > 0; k++) step(tk, 1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    int lowcnt, wraps, prev;
    logic [15:0] pb;
    total = 0; bad = 0;
    rst = 1'b1; sample_tick = 1'b0; note_valid = 1'b0;
    note_chan = '0; note = '0; octave = '0; retrig = 1'b0;
    model_clear();

    // Reset and idle ticks
    do_reset();
    chk("rst_state", 64'(dbg_state), 64'(LD_IDLE));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);

    // Note 9, octave 0 on channel 0
    load(0, 9, 0, 1'b1, 1'b0);
    for (int t = 1; t <= 7; t++) begin
      step(1'b1, 1'b0, 0, 0, 0, 1'b0);
      if (t == 1) chk("n9_t1", 64'(ph(0)), 64'd28);
      if (t == 6) chk("n9_t6", 64'(ph(0)), 64'd168);
      if (t == 7) chk("n9_t7", 64'(ph(0)), 64'd197);
    end

    // Octave reduction and ready-low duration
    lowcnt = 0;
    step(1'b0, 1'b1, 1, 0, 1, 1'b1);
    for (int k = 0; k < 10 && !note_ready; k++) begin
      lowcnt++;
      step(1'b0, 1'b0, 0, 0, 0, 1'b0);
    end
    chk("ready_low_cycles", 64'(lowcnt), 64'd3);
    load(2, 12, 0, 1'b1, 1'b0);
    load(0, 9, 1, 1'b1, 1'b0);
    for (int t = 1; t <= 5; t++) begin
      step(1'b1, 1'b0, 0, 0, 0, 1'b0);
      chk("oct_eq", 64'(ph(1)), 64'(ph(2)));
      if (t == 1) begin
        chk("n0o1_t1", 64'(ph(1)), 64'd33);
        chk("n9o1_t1", 64'(ph(0)), 64'd56);
      end
    end

    // Wrap on channel 3
    load(3, 23, 3, 1'b1, 1'b0);
    wraps = 0;
    for (int t = 0; t < 200; t++) begin
      prev = int'(ph(3));
      step(1'b1, 1'b0, 0, 0, 0, 1'b0);
      if (int'(ph(3)) < prev) wraps++;
    end
    chk("wrap_seen", 64'(wraps > 0), 64'd1);

    // Phase-continuous note change
    pb = ph(3);
    load(3, 2, 0, 1'b0, 1'b0);
    chk("continuity", 64'(ph(3)), 64'(pb));
    for (int t = 0; t < 4; t++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);

    // Retrig commit coinciding with a tick
    load(1, 5, 2, 1'b1, 1'b1);
    chk("retrig_tick", 64'(ph(1)), 64'd0);
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);

    // Key-off among four running channels
    load(0, 3, 0, 1'b1, 1'b0);
    load(1, 7, 1, 1'b1, 1'b0);
    load(2, 11, 0, 1'b1, 1'b0);
    load(3, 19, 2, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    load(2, 31, 0, 1'b0, 1'b1);
    chk("koff_active", 64'(active), 64'b1011);
    chk("koff_phase", 64'(ph(2)), 64'd0);
    for (int t = 0; t < 5; t++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);

    // note_valid held while busy with changing data
    step(1'b0, 1'b1, 2, 10, 2, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 2, 1, 0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 0, 1'b0);
    chk("hold_inc", 64'(ph(2)), 64'd119);

    // Reset while in SHIFT
    step(1'b0, 1'b1, 0, 4, 3, 1'b1);
    step(1'b0, 1'b0, 0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 0, 1'b0);
    chk("shift_state", 64'(dbg_state), 64'(LD_SHIFT));
    do_reset();
    chk("rst_mid_load", 64'(dbg_state), 64'(LD_IDLE));
    for (int t = 0; t < 3; t++) step(1'b1, 1'b0, 0, 0, 0, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      int nt;
      nt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(24, 31)) : int'($urandom_range(0, 23));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 3)), nt, int'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_phase_bank.md
Name: tone_phase_bank

Overview:
- Multi-channel tone generator core: converts note index plus octave into a fixed-point phase increment and runs one phase accumulator per channel.
- Increment = integer jump plus fractional remainder modulo FRAC_DEN; the fractional carry gives exact average pitch.
- Successor to the single-note jump/remainder lookup: adds channels, octave shifting, phase-continuous note changes, retrigger and key-off.
- Sits between the keyboard/sequencer front end and the waveform/DAC stage.

Parameters:
- CHANNELS, 4, number of independent voices.
- PHASE_W, 16, phase accumulator width; wraps mod 2^PHASE_W.
- NOTE_W, 5, note index width.
- NOTES, 24, valid note indices 0..NOTES-1.
- OCT_W, 2, octave shift width (0..3).
- JUMP_W, 7, base table integer width.
- REM_W, 29, remainder width.
- FRAC_DEN, 100000000, fractional modulus.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe; advances all active accumulators.
- note_valid  in  1  load request.
- note_ready  out  1  high when the loader is idle (IDLE state); a transfer occurs when note_valid and note_ready are both high.
- note_chan  in  clog2(CHANNELS)  target channel.
- note  in  NOTE_W  note index; a value >= NOTES means key-off.
- octave  in  OCT_W  upward octave shift.
- retrig  in  1  when set, clears phase and frac at commit.
- phase  out  CHANNELS*PHASE_W  flattened accumulators; channel 0 in the LSBs.
- active  out  CHANNELS  channel has a committed note.

Behaviour:
- Reset state: all phase, frac, jump and rem registers are 0; active=0; loader in IDLE; note_ready=1.
- Reset mid-load aborts the load; the channel is left untouched apart from the reset clear.
- Loader FSM states: IDLE, LOOKUP, SHIFT, COMMIT.
- IDLE: on transfer, capture note_chan, note, octave and retrig, then go to LOOKUP. note_ready is 0 in every state other than IDLE.
- LOOKUP (1 cycle): register the table entry into (j, r).
  - For a key-off note, go directly to COMMIT.
  - Otherwise set count=octave and go to SHIFT if count != 0, else to COMMIT.
- SHIFT (one cycle per octave):
  - j = 2j, r = 2r.
  - If r >= FRAC_DEN then r -= FRAC_DEN and j += 1. One subtraction always suffices because r < FRAC_DEN is an invariant.
  - Decrement count; leave for COMMIT when it reaches 0.
- COMMIT (1 cycle): write j and r into the channel's increment registers and set active=1, then return to IDLE. Total latency from transfer to new increment is 2+octave cycles.
- Key-off commit: jump=0, rem=0, phase=0, frac=0, active=0.
- Internal increment width: INC_W = JUMP_W + 2^OCT_W - 1 bits, so shifted jumps never overflow.
- Tick update, per active channel, on a cycle with sample_tick=1:
  - s = frac + rem.
  - carry = (s >= FRAC_DEN); frac = s - carry*FRAC_DEN.
  - phase = phase + jump + carry, mod 2^PHASE_W.
- Inactive channels hold phase=0 on a tick.
- Note change without retrig is phase-continuous: phase and frac are kept and only the increment changes.
- Tick coinciding with COMMIT on the same channel:
  - With retrig or key-off, the commit wins: phase=0, frac=0 at that edge.
  - Otherwise the tick uses the old increment and the new one takes effect from the next tick.
- Ticks always update every channel, including while the loader is busy.
- phase is registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package/include holds:
  - FRAC_DEN.
  - The NOTES-entry jump/remainder constant table, e.g. note 0 = (16, 74403618), note 9 = (28, 16000000), note 12 = (33, 48807236), note 21 = (56, 32000000).
  - The loader state encoding.
- One sub-module, tone_note_rom: combinational note -> (jump, rem), returning (0, 0) for out-of-range notes. It is instantiated once, shared by the loader.

Test Plan:
- Reset then idle: phase=0, active=0 and note_ready=1 after rst; ticks leave every output at 0.
- Load note 9, octave 0, channel 0, retrig=1, then 7 ticks: phase after tick 1 = 28, after tick 6 = 168 with frac=96000000, after tick 7 = 197 with frac=12000000.
- Octave reduction: note 0 with octave 1 commits jump=33, rem=48807236, identical to note 12 octave 0. note 9 with octave 1 commits jump=56, rem=32000000. note_ready is low for exactly 3 cycles in the octave-1 case.
- Wrap and continuity:
  - Preload phase near 65535 via ticks; the tick that crosses the boundary wraps mod 65536.
  - A note change without retrig mid-run keeps phase and frac.
  - A commit with retrig on the same cycle as a tick gives phase=0.
- Key-off and multi-channel: load channels 0..3 with different notes, then load note 31 to channel 2 → active=1011b, channel 2 phase=0, other channels keep advancing on every tick.
- Handshake and reset: note_valid held during busy causes no second capture; asserting rst during SHIFT returns the loader to IDLE with all channels cleared.
